// File: rtl/weight_bram_reader.sv
// Read-side controller for a per-neuron weight BRAM. It issues DEPTH sequential reads
// and streams the returned words over valid/ready through a 2-entry skid buffer.
module weight_bram_reader #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DEPTH     = 28,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              WE,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [DATA_W-1:0] W_DATA,
  output logic [ADDR_W-1:0] W_IDX,
  output logic              W_LAST,
  output logic              W_VALID,
  input  logic              W_READY
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   fl_idx_q, fl_idx_d;
  logic                fl_last_q, fl_last_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   buf_data_q [2];
  logic [DATA_W-1:0]   buf_data_d [2];
  logic [ADDR_W-1:0]   buf_idx_q  [2];
  logic [ADDR_W-1:0]   buf_idx_d  [2];
  logic                buf_last_q [2];
  logic                buf_last_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic                pop;
  logic                push;
  logic [2:0]          level;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    fl_idx_d    = fl_idx_q;
    fl_last_d   = fl_last_q;
    done_d      = 1'b0;
    buf_data_d  = buf_data_q;
    buf_idx_d   = buf_idx_q;
    buf_last_d  = buf_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    pop  = (count_q != 2'd0) && W_READY;
    push = en_q;
    // Occupancy after this edge, counting the read that lands now; a new issue lands next edge.
    level = {1'b0, count_q} + {2'b00, en_q} - {2'b00, pop};

    if (push) begin
      buf_data_d[wr_ptr_q] = RD_DATA;
      buf_idx_d[wr_ptr_q]  = fl_idx_q;
      buf_last_d[wr_ptr_q] = fl_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d     = S_FETCH;
          issue_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (issue_cnt_q == DEPTH_C) begin
          state_d = S_DRAIN;
        end else if (level < 3'd2) begin
          en_d        = 1'b1;
          addr_d      = BASE_C + ADDR_W'(issue_cnt_q);
          fl_idx_d    = ADDR_W'(issue_cnt_q);
          fl_last_d   = (issue_cnt_q == DEPTH_C - 1'b1);
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (pop && buf_last_q[rd_ptr_q] && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      fl_idx_q    <= '0;
      fl_last_q   <= 1'b0;
      done_q      <= 1'b0;
      buf_data_q  <= '{default: '0};
      buf_idx_q   <= '{default: '0};
      buf_last_q  <= '{default: 1'b0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      fl_idx_q    <= fl_idx_d;
      fl_last_q   <= fl_last_d;
      done_q      <= done_d;
      buf_data_q  <= buf_data_d;
      buf_idx_q   <= buf_idx_d;
      buf_last_q  <= buf_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;
  assign ADDR    = addr_q;
  assign EN      = en_q;
  assign WE      = 1'b0;
  assign DI      = '0;
  assign W_DATA  = buf_data_q[rd_ptr_q];
  assign W_IDX   = buf_idx_q[rd_ptr_q];
  assign W_LAST  = buf_last_q[rd_ptr_q];
  assign W_VALID = (count_q != 2'd0);

endmodule
